// File: rtl/shift_unloader_pkg.sv
// Shared definitions for the shift unloader: FSM encoding and sizing constants.
package shift_unloader_pkg;

   localparam int unsigned WORD_WIDTH   = 8;
   localparam int unsigned UNLOAD_DEPTH = 3;
   localparam int unsigned BEAT_WIDTH   = 2;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SEND = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/shift_unloader_beat_counter.sv
// Mod-3 beat counter: synchronous clear, advances by one per enabled cycle, wraps 2 -> 0.
module unloader_beat_counter
   import shift_unloader_pkg::*;
(
   input  logic                  clk,
   input  logic                  clear,
   input  logic                  advance,
   output logic [BEAT_WIDTH-1:0] count
);

   localparam logic [BEAT_WIDTH-1:0] MAX_COUNT = BEAT_WIDTH'(UNLOAD_DEPTH - 1);

   // Count register; clear has priority, wrap keeps the value below 3.
   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (advance) begin
         if (count == MAX_COUNT) begin
            count <= '0;
         end else begin
            count <= count + BEAT_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/shift_unloader.sv
// Captures three operand words on a load request and offers them oldest-first
// over a valid/ready handshake, followed by a one-cycle completion strobe.
module shift_unloader
   import shift_unloader_pkg::*;
#(
   parameter int WIDTH = WORD_WIDTH,
   parameter int DEPTH = UNLOAD_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_pulse,
   input  logic [WIDTH-1:0] reg1_in,
   input  logic [WIDTH-1:0] reg2_in,
   input  logic [WIDTH-1:0] reg3_in,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             busy,
   output logic             done_pulse
);

   localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(DEPTH - 1);

   state_t                state_q;
   state_t                state_d;
   logic [WIDTH-1:0]      hold3;
   logic [WIDTH-1:0]      hold2;
   logic [WIDTH-1:0]      hold1;
   logic [BEAT_WIDTH-1:0] beat_count;
   logic                  capture;
   logic                  transfer;

   assign capture  = (state_q == IDLE) && load_pulse;
   assign transfer = (state_q == SEND) && out_ready;

   unloader_beat_counter u_beat (
      .clk     (clk),
      .clear   (reset),
      .advance (transfer),
      .count   (beat_count)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Holding registers load only from IDLE, so loads during a burst are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold3 <= '0;
         hold2 <= '0;
         hold1 <= '0;
      end else if (capture) begin
         hold3 <= reg3_in;
         hold2 <= reg2_in;
         hold1 <= reg1_in;
      end
   end

   // Next-state logic and status outputs.
   always_comb begin
      state_d    = state_q;
      data_valid = 1'b0;
      busy       = 1'b0;
      done_pulse = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_pulse) begin
               state_d = SEND;
            end
         end
         SEND: begin
            data_valid = 1'b1;
            busy       = 1'b1;
            if (out_ready && (beat_count == LAST_BEAT)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            done_pulse = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Word select: oldest word first, forced to zero whenever nothing is offered.
   always_comb begin
      data_out = '0;
      if (state_q == SEND) begin
         case (beat_count)
            2'd0:    data_out = hold3;
            2'd1:    data_out = hold2;
            default: data_out = hold1;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_unloader.sv
// Self-checking bench for shift_unloader: directed scenarios plus a randomized
// run compared cycle by cycle against a queue-based behavioural model.
module tb_shift_unloader;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         load_pulse = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] reg1_in = '0;
   logic [W-1:0] reg2_in = '0;
   logic [W-1:0] reg3_in = '0;
   logic [W-1:0] data_out;
   logic         data_valid;
   logic         busy;
   logic         done_pulse;

   int n_cmp = 0;
   int n_err = 0;

   // Model: words still to be delivered, and whether a completion strobe is due.
   logic [W-1:0] m_q[$];
   bit           m_done = 1'b0;

   // Observations gathered by collect().
   logic [W-1:0] got[$];
   bit           got_done;

   always #5 clk = ~clk;

   shift_unloader #(.WIDTH(W), .DEPTH(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_pulse (load_pulse),
      .reg1_in    (reg1_in),
      .reg2_in    (reg2_in),
      .reg3_in    (reg3_in),
      .out_ready  (out_ready),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (busy),
      .done_pulse (done_pulse)
   );

   function automatic void model_edge();
      if (reset) begin
         m_q.delete();
         m_done = 1'b0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_q.size() != 0) begin
         if (out_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_done = 1'b1;
         end
      end else if (load_pulse) begin
         m_q.push_back(reg3_in);
         m_q.push_back(reg2_in);
         m_q.push_back(reg1_in);
      end
   endfunction

   // Expected {data_valid, busy, done_pulse, data_out} from the model.
   function automatic logic [W+2:0] model_vec();
      logic v;
      v = (m_q.size() != 0);
      return {v, v | m_done, m_done, v ? m_q[0] : {W{1'b0}}};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic collect(input int max_cycles);
      got.delete();
      got_done = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         if (done_pulse === 1'b1) begin
            got_done = 1'b1;
            break;
         end
         if (data_valid === 1'b1 && out_ready === 1'b1) got.push_back(data_out);
         tick();
      end
   endtask

   task automatic load_words(input logic [W-1:0] w3, input logic [W-1:0] w2, input logic [W-1:0] w1);
      reg3_in = w3;
      reg2_in = w2;
      reg1_in = w1;
      load_pulse = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      load_words(8'hAA, 8'hBB, 8'hCC);
      out_ready = 1'b1;
      tick();
      tick();
      n_cmp++;
      if ({data_valid, busy, done_pulse, data_out} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got v=%b b=%b d=%b data=%h, expected all zero",
                  data_valid, busy, done_pulse, data_out);
      end
      n_cmp++;
      if (dut.beat_count !== 2'd0) begin
         n_err++;
         $display("FAIL reset_beat: got %0d expected 0", dut.beat_count);
      end
      reset = 1'b0;
      load_pulse = 1'b0;
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_no_start: busy got %b expected 0", busy);
      end
   endtask

   task automatic test_nominal();
      logic [W-1:0] exp_w[3];
      exp_w[0] = 8'h0A; exp_w[1] = 8'h14; exp_w[2] = 8'h1E;
      out_ready = 1'b1;
      load_words(8'h0A, 8'h14, 8'h1E);
      tick();
      load_pulse = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (data_valid !== 1'b1 || data_out !== exp_w[i] || busy !== 1'b1) begin
            n_err++;
            $display("FAIL nominal_word%0d: got v=%b data=%h busy=%b expected v=1 data=%h busy=1",
                     i, data_valid, data_out, busy, exp_w[i]);
         end
         tick();
      end
      n_cmp++;
      if (done_pulse !== 1'b1 || data_valid !== 1'b0 || data_out !== 8'h00 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL nominal_done: got d=%b v=%b data=%h busy=%b expected d=1 v=0 data=00 busy=1",
                  done_pulse, data_valid, data_out, busy);
      end
      tick();
      n_cmp++;
      if (busy !== 1'b0 || done_pulse !== 1'b0) begin
         n_err++;
         $display("FAIL nominal_idle: got busy=%b d=%b expected 0 0", busy, done_pulse);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      load_words(8'h0A, 8'h14, 8'h1E);
      tick();
      load_pulse = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         n_cmp++;
         if (data_valid !== 1'b1 || data_out !== 8'h0A) begin
            n_err++;
            $display("FAIL backpressure_hold_N+%0d: got v=%b data=%h expected v=1 data=0a",
                     c, data_valid, data_out);
         end
         tick();
      end
      out_ready = 1'b1;
      collect(10);
      n_cmp++;
      if (!got_done || got.size() != 3 || got[0] !== 8'h0A || got[1] !== 8'h14 || got[2] !== 8'h1E) begin
         n_err++;
         $display("FAIL backpressure_sequence: got %0d words %p done=%b expected 0a 14 1e done=1",
                  got.size(), got, got_done);
      end
      tick();
   endtask

   task automatic test_load_while_busy();
      bit saw_ff;
      saw_ff = 1'b0;
      out_ready = 1'b1;
      load_words(8'h0A, 8'h14, 8'h1E);
      tick();
      load_pulse = 1'b0;
      n_cmp++;
      if (data_out !== 8'h0A) begin
         n_err++;
         $display("FAIL busy_load_word0: got %h expected 0a", data_out);
      end
      tick();
      load_words(8'hFF, 8'hEE, 8'hDD);
      n_cmp++;
      if (data_out !== 8'h14) begin
         n_err++;
         $display("FAIL busy_load_word1: got %h expected 14", data_out);
      end
      tick();
      load_pulse = 1'b0;
      n_cmp++;
      if (data_out !== 8'h1E || data_valid !== 1'b1) begin
         n_err++;
         $display("FAIL busy_load_word2: got v=%b data=%h expected v=1 data=1e", data_valid, data_out);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         if (data_valid === 1'b1 && data_out === 8'hFF) saw_ff = 1'b1;
      end
      n_cmp++;
      if (saw_ff || busy !== 1'b0) begin
         n_err++;
         $display("FAIL busy_load_ignored: got saw_ff=%b busy=%b expected 0 0", saw_ff, busy);
      end
   endtask

   task automatic test_midburst_reset();
      bit saw_done;
      saw_done = 1'b0;
      out_ready = 1'b1;
      load_words(8'h0A, 8'h14, 8'h1E);
      tick();
      load_pulse = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++;
      if (data_valid !== 1'b0 || busy !== 1'b0 || done_pulse !== 1'b0 || data_out !== 8'h00) begin
         n_err++;
         $display("FAIL midreset_abort: got v=%b b=%b d=%b data=%h expected 0 0 0 00",
                  data_valid, busy, done_pulse, data_out);
      end
      for (int i = 0; i < 5; i++) begin
         if (done_pulse === 1'b1) saw_done = 1'b1;
         tick();
      end
      n_cmp++;
      if (saw_done) begin
         n_err++;
         $display("FAIL midreset_no_done: got done_pulse seen=1 expected 0");
      end
      load_words(8'h55, 8'h66, 8'h77);
      tick();
      load_pulse = 1'b0;
      n_cmp++;
      if (data_valid !== 1'b1 || data_out !== 8'h55) begin
         n_err++;
         $display("FAIL midreset_fresh: got v=%b data=%h expected v=1 data=55", data_valid, data_out);
      end
      collect(10);
      n_cmp++;
      if (!got_done || got.size() != 3 || got[0] !== 8'h55 || got[1] !== 8'h66 || got[2] !== 8'h77) begin
         n_err++;
         $display("FAIL midreset_sequence: got %p done=%b expected 55 66 77 done=1", got, got_done);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      load_words(8'h10, 8'h20, 8'h30);
      tick();
      load_pulse = 1'b0;
      collect(10);
      n_cmp++;
      if (!got_done || got.size() != 3 || got[0] !== 8'h10 || got[1] !== 8'h20 || got[2] !== 8'h30) begin
         n_err++;
         $display("FAIL b2b_first: got %p done=%b expected 10 20 30 done=1", got, got_done);
      end
      tick();
      load_words(8'h01, 8'h02, 8'h03);
      tick();
      load_pulse = 1'b0;
      collect(10);
      n_cmp++;
      if (!got_done || got.size() != 3 || got[0] !== 8'h01 || got[1] !== 8'h02 || got[2] !== 8'h03) begin
         n_err++;
         $display("FAIL b2b_second: got %p done=%b expected 01 02 03 done=1", got, got_done);
      end
      tick();
   endtask

   task automatic test_held_load();
      int dones;
      dones = 0;
      out_ready = 1'b1;
      load_words(8'hA1, 8'hA2, 8'hA3);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done_pulse === 1'b1) dones++;
      end
      load_pulse = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (done_pulse === 1'b1) dones++;
         tick();
      end
      n_cmp++;
      if (dones != 1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL held_load_one_burst: got %0d done pulses busy=%b expected 1 busy=0", dones, busy);
      end
   endtask

   task automatic test_random();
      logic [W+2:0] exp_v;
      for (int i = 0; i < 600; i++) begin
         exp_v = model_vec();
         n_cmp++;
         if ({data_valid, busy, done_pulse, data_out} !== exp_v) begin
            n_err++;
            $display("FAIL random_cycle%0d: got v=%b b=%b d=%b data=%h expected v=%b b=%b d=%b data=%h",
                     i, data_valid, busy, done_pulse, data_out,
                     exp_v[W+2], exp_v[W+1], exp_v[W], exp_v[W-1:0]);
         end
         if (dut.beat_count === 2'd3) begin
            n_cmp++;
            n_err++;
            $display("FAIL random_beat_range: got 3 expected 0..2");
         end
         reset      = ($urandom_range(39, 0) == 0);
         load_pulse = ($urandom_range(3, 0) == 0);
         out_ready  = ($urandom_range(9, 0) < 6);
         reg1_in    = W'($urandom);
         reg2_in    = W'($urandom);
         reg3_in    = W'($urandom);
         tick();
      end
      reset = 1'b0;
      load_pulse = 1'b0;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_backpressure();
      test_load_while_busy();
      test_midburst_reset();
      test_back_to_back();
      test_held_load();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shift_unloader.md
SHIFT_UNLOADER -- requirements
Module: shift_unloader

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each operand word.
REQ-002 Parameter DEPTH, fixed at 3, number of words unloaded per burst; the value 3 is the only supported value.
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 Port load_pulse  input  1  one-cycle request to capture the three operand words and start a burst.
REQ-006 Port reg1_in  input  WIDTH  newest operand word.
REQ-007 Port reg2_in  input  WIDTH  middle operand word.
REQ-008 Port reg3_in  input  WIDTH  oldest operand word.
REQ-009 Port out_ready  input  1  downstream consumer can accept a word this cycle.
REQ-010 Port data_out  output  WIDTH  current word being offered.
REQ-011 Port data_valid  output  1  data_out holds a valid word.
REQ-012 Port busy  output  1  a burst is in progress, so a new load is refused.
REQ-013 Port done_pulse  output  1  one-cycle strobe after the last word is accepted.

Function
REQ-014 The FSM SHALL have three states: IDLE, SEND and DONE.
REQ-015 In IDLE, load_pulse=1 SHALL capture reg3_in, reg2_in and reg1_in into internal holding registers and move the FSM to SEND on the next edge.
REQ-016 The first word SHALL appear one cycle after load_pulse: data_valid=1 and data_out=captured reg3 in cycle N+1.
REQ-017 The word order SHALL be reg3, then reg2, then reg1, which is oldest-first.
REQ-018 A transfer SHALL occur only in a cycle with data_valid=1 and out_ready=1.
REQ-019 Each transfer SHALL advance to the next word at the next edge.
REQ-020 If out_ready is held high, the block SHALL transfer one word per cycle.
REQ-021 While data_valid=1 and out_ready=0, data_out and data_valid SHALL hold unchanged, with no word dropped or repeated.
REQ-022 The transfer of the third word SHALL move the FSM to DONE.
REQ-023 DONE SHALL last exactly one cycle with done_pulse=1 and data_valid=0, then the FSM SHALL return to IDLE.
REQ-024 busy SHALL be 1 in SEND and DONE, and 0 in IDLE.
REQ-025 load_pulse SHALL be ignored in SEND and DONE: the holding registers and the beat count are unchanged.
REQ-026 A load_pulse held high for several IDLE cycles SHALL start exactly one burst.
REQ-027 The beat counter SHALL count 0 to 2 and wrap to 0 on entry to DONE.
REQ-028 The beat counter SHALL never reach 3.
REQ-029 data_out SHALL be 0 whenever data_valid=0.
REQ-030 Input words SHALL pass through unmodified, with no arithmetic or width change.

Reset
REQ-031 reset=1 at a clk edge SHALL force IDLE, beat count 0, holding registers 0, data_out=0, data_valid=0, busy=0 and done_pulse=0.
REQ-032 reset SHALL take priority over load_pulse and out_ready in the same cycle.
REQ-033 A reset in the middle of a burst SHALL abort the burst with no done_pulse.
REQ-034 After a mid-burst reset, the next load_pulse SHALL start a fresh burst from reg3.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding (IDLE=2'b00, SEND=2'b01, DONE=2'b10) and the constants WORD_WIDTH=8 and UNLOAD_DEPTH=3.
REQ-036 The beat counter SHALL be a separate sub-module, unloader_beat_counter: a mod-3 counter with synchronous clear and an advance enable.
REQ-037 The word multiplexer and the FSM SHALL stay in shift_unloader.

Verification
REQ-038 Nominal burst: reset, then load_pulse with reg3=0x0A, reg2=0x14, reg1=0x1E and out_ready=1 -> data_out 0x0A, 0x14, 0x1E in cycles N+1..N+3, then done_pulse=1 in N+4, and busy=0 in N+5.
REQ-039 Backpressure: same load, with out_ready=0 for cycles N+1..N+3 and 1 afterwards -> data_out=0x0A stable with data_valid=1 through N+3, then the full sequence completes with no duplicate words.
REQ-040 Load while busy: a second load_pulse with reg3=0xFF in cycle N+2 -> the burst is still 0x0A, 0x14, 0x1E and 0xFF never appears.
REQ-041 Mid-burst reset: reset asserted in cycle N+2 -> N+3 shows data_valid=0, busy=0 and no done_pulse; a new load with reg3=0x55 -> first word 0x55.
REQ-042 Back-to-back bursts: load_pulse in the cycle after done_pulse with reg3=0x01, reg2=0x02, reg1=0x03 -> a second burst 0x01, 0x02, 0x03 with no stale data from the first burst.
